sobel_window_ctrl: RTL and testbench

- Streaming controller that sequences the combinational 3x3 Sobel edge filter across a raster-order 12-bit pixel stream.
- Owns two line buffers and a 3x3 tap window, and tracks frame position (column/row counters).
- Drives the nine window taps to the filter and samples its 1-bit edge result.
- Emits an edge stream tagged with centre coordinates; sits between the camera/VGA pixel source and the motion-recognition logic.

---
 rtl/sobel_window_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Raster-stream 3x3 window sequencer feeding an external combinational Sobel filter.
// Optional macro SOBEL_EDGE_STATS_EN adds a per-frame edge_count output.
module sobel_window_ctrl #(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240,
    parameter int unsigned DW    = 12
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_pixel,
    output logic [DW-1:0] win00,
    output logic [DW-1:0] win01,
    output logic [DW-1:0] win02,
    output logic [DW-1:0] win10,
    output logic [DW-1:0] win11,
    output logic [DW-1:0] win12,
    output logic [DW-1:0] win20,
    output logic [DW-1:0] win21,
    output logic [DW-1:0] win22,
    output logic          win_valid,
    input  logic          edge_in,
    output logic          out_valid,
    output logic          out_edge,
    output logic [8:0]    out_x,
    output logic [7:0]    out_y,
    output logic          frame_done,
    output logic          sof_err
`ifdef SOBEL_EDGE_STATS_EN
    ,
    output logic [17:0]   edge_count
`endif
);
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned AW = $clog2(IMG_W);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [DW-1:0] w [3][3];
    logic          held_vld;
    logic [DW-1:0] held_pix;
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb2 [IMG_W];

    logic          start_c;
    logic          resync_c;
    logic          accept_c;
    logic          last_c;
    logic          win_ok_c;
    logic [XW-1:0] ax_c;
    logic [YW-1:0] ay_c;
    logic [AW-1:0] ra_c;
    logic [DW-1:0] pix_c;
    logic [DW-1:0] lb1_rd_c;
    logic [DW-1:0] lb2_rd_c;

    assign win00 = w[0][0];
    assign win01 = w[0][1];
    assign win02 = w[0][2];
    assign win10 = w[1][0];
    assign win11 = w[1][1];
    assign win12 = w[1][2];
    assign win20 = w[2][0];
    assign win21 = w[2][1];
    assign win22 = w[2][2];

    // Accept decode; a start-of-frame pixel (fresh, held or resync) always lands at (0,0)
    always_comb begin
        start_c  = (state == IDLE) && (held_vld || (in_valid && in_sof));
        resync_c = (state == RUN) && in_valid && in_sof;
        accept_c = start_c || ((state == RUN) && in_valid);
        pix_c    = held_vld ? held_pix : in_pixel;
        ax_c     = (start_c || resync_c) ? '0 : x;
        ay_c     = (start_c || resync_c) ? '0 : y;
        ra_c     = AW'(ax_c);
        lb1_rd_c = lb1[ra_c];
        lb2_rd_c = lb2[ra_c];
        last_c   = (ax_c == XW'(IMG_W - 1)) && (ay_c == YW'(IMG_H - 1));
        win_ok_c = (ax_c >= XW'(2)) && (ay_c >= YW'(2));
    end

    // Line buffers: LB1 holds the previous line, LB2 the one before it
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lb2[ra_c] <= lb1_rd_c;
            lb1[ra_c] <= pix_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            cx         <= '0;
            cy         <= '0;
            held_vld   <= 1'b0;
            held_pix   <= '0;
            win_valid  <= 1'b0;
            out_valid  <= 1'b0;
            out_edge   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r][c] <= '0;
                end
            end
        end else begin
            win_valid  <= accept_c && win_ok_c;
            // A resync kills the window already handed to the filter
            out_valid  <= win_valid && !resync_c;
            out_edge   <= win_valid && !resync_c && edge_in;
            sof_err    <= resync_c;
            frame_done <= 1'b0;
            if (win_valid) begin
                out_x <= cx;
                out_y <= cy;
            end
            if (accept_c) begin
                for (int r = 0; r < 3; r++) begin
                    w[r][0] <= w[r][1];
                    w[r][1] <= w[r][2];
                end
                w[0][2] <= lb2_rd_c;
                w[1][2] <= lb1_rd_c;
                w[2][2] <= pix_c;
                if (ax_c == XW'(IMG_W - 1)) begin
                    x <= '0;
                    y <= (ay_c == YW'(IMG_H - 1)) ? '0 : ay_c + YW'(1);
                end else begin
                    x <= ax_c + XW'(1);
                    y <= ay_c;
                end
                if (win_ok_c) begin
                    cx <= ax_c - XW'(1);
                    cy <= ay_c - YW'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state    <= RUN;
                        held_vld <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept_c && last_c) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last window is at the filter now; its result leaves with frame_done
                    frame_done <= 1'b1;
                    state      <= IDLE;
                    if (in_valid && in_sof) begin
                        held_vld <= 1'b1;
                        held_pix <= in_pixel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOBEL_EDGE_STATS_EN
    localparam int unsigned CW = 18;

    logic [CW-1:0] edge_acc;
    logic          edge_hit_c;

    assign edge_hit_c = win_valid && !resync_c && edge_in;

    // Edge tally, published together with frame_done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_acc   <= '0;
            edge_count <= '0;
        end else if (resync_c) begin
            edge_acc <= '0;
        end else if (state == DRAIN) begin
            edge_count <= edge_acc + CW'(edge_hit_c);
            edge_acc   <= '0;
        end else begin
            edge_acc <= edge_acc + CW'(edge_hit_c);
        end
    end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomized bench for sobel_window_ctrl: image-level model with a real Sobel filter on edge_in.
module tb_sobel_window_ctrl;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int DW   = 12;
    localparam int NOUT = (W - 2) * (H - 2);
    localparam int NPIX = W * H;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof   = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic [DW-1:0] win00, win01, win02, win10, win11, win12, win20, win21, win22;
    logic          win_valid, edge_in, out_valid, out_edge, frame_done, sof_err;
    logic [8:0]    out_x;
    logic [7:0]    out_y;
`ifdef SOBEL_EDGE_STATS_EN
    logic [17:0]   edge_count;
    logic [17:0]   ec_at_fd = '0;
`endif

    always #5 clk = ~clk;

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .win00(win00), .win01(win01), .win02(win02), .win10(win10), .win11(win11),
        .win12(win12), .win20(win20), .win21(win21), .win22(win22),
        .win_valid(win_valid), .edge_in(edge_in), .out_valid(out_valid), .out_edge(out_edge),
        .out_x(out_x), .out_y(out_y), .frame_done(frame_done), .sof_err(sof_err)
`ifdef SOBEL_EDGE_STATS_EN
        , .edge_count(edge_count)
`endif
    );

    int total = 0, bad = 0, cyc = 0, fd_cnt = 0, fd_cyc = 0, se_cnt = 0;
    bit fd_with_ov = 1'b0;
    logic [DW-1:0] img [H][W];
    int drv_cyc [NPIX];
    int tap [9];

    typedef struct { int x; int y; bit e; int cyc; } out_t;
    typedef struct { logic [8:0][DW-1:0] t; int cyc; } win_t;
    out_t got_q[$];
    win_t win_q[$];

    logic [DW+9+8+5-1:0] all_out;
    assign all_out = {win00 | win01 | win02 | win10 | win11 | win12 | win20 | win21 | win22,
                      out_x, out_y, win_valid, out_valid, out_edge, frame_done, sof_err};

    function automatic bit sobel_edge(input int p [9]);
        int gx, gy;
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[6] + 2 * p[7] + p[8]) - (p[0] + 2 * p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy) > 6000;
    endfunction

    // The filter the controller drives: purely combinational on the taps
    always_comb begin
        tap[0] = int'(win00); tap[1] = int'(win01); tap[2] = int'(win02);
        tap[3] = int'(win10); tap[4] = int'(win11); tap[5] = int'(win12);
        tap[6] = int'(win20); tap[7] = int'(win21); tap[8] = int'(win22);
        edge_in = sobel_edge(tap);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid) got_q.push_back('{x: int'(out_x), y: int'(out_y), e: out_edge, cyc: cyc});
            if (win_valid) win_q.push_back('{t: {win22, win21, win20, win12, win11, win10, win02, win01, win00}, cyc: cyc});
            if (frame_done) begin
                fd_cnt++;
                fd_cyc     = cyc;
                fd_with_ov = out_valid;
`ifdef SOBEL_EDGE_STATS_EN
                ec_at_fd   = edge_count;
`endif
            end
            if (sof_err) se_cnt++;
        end
    end

    // Reference: edge decision for window centre (cx,cy) computed straight from the image
    function automatic bit exp_edge(input int cx, input int cy);
        int p [9];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r * 3 + c] = int'(img[cy - 1 + r][cx - 1 + c]);
        return sobel_edge(p);
    endfunction

    function automatic int model_edges();
        int n = 0;
        for (int cy = 1; cy < H - 1; cy++)
            for (int cx = 1; cx < W - 1; cx++)
                if (exp_edge(cx, cy)) n++;
        return n;
    endfunction

    function automatic int n_out_after(input int from);
        int n = 0;
        foreach (got_q[i]) if (got_q[i].cyc > from) n++;
        return n;
    endfunction

    function automatic int n_edges_after(input int from);
        int n = 0;
        foreach (got_q[i]) if (got_q[i].cyc > from && got_q[i].e) n++;
        return n;
    endfunction

    // Number of outputs after 'from' that disagree with the raster-order expectation
    function automatic int out_diffs(input int from, input bit lat);
        int n = 0, j = 0, cx, cy;
        foreach (got_q[i]) begin
            if (got_q[i].cyc > from) begin
                if (j >= NOUT) n++;
                else begin
                    cx = 1 + j % (W - 2);
                    cy = 1 + j / (W - 2);
                    if (got_q[i].x != cx || got_q[i].y != cy || got_q[i].e != exp_edge(cx, cy)) n++;
                    else if (lat && (got_q[i].cyc - drv_cyc[(cy + 1) * W + cx + 1] != 2)) n++;
                end
                j++;
            end
        end
        return n;
    endfunction

    function automatic int win_diffs(input int from);
        int n = 0, j = 0, cx, cy;
        bit d;
        foreach (win_q[i]) begin
            if (win_q[i].cyc > from) begin
                d = (j >= NOUT);
                if (!d) begin
                    cx = 1 + j % (W - 2);
                    cy = 1 + j / (W - 2);
                    for (int r = 0; r < 3; r++)
                        for (int c = 0; c < 3; c++)
                            if (win_q[i].t[r * 3 + c] !== img[cy - 1 + r][cx - 1 + c]) d = 1'b1;
                end
                if (d) n++;
                j++;
            end
        end
        return n;
    endfunction

    task automatic set_flat();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 12'h800;
    endtask

    task automatic set_step();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = (x < 4) ? 12'h000 : 12'hFFF;
    endtask

    task automatic set_random();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = DW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_sof   = 1'($urandom);
            in_pixel = DW'($urandom);
        end
    endtask

    task automatic send(input logic [DW-1:0] p, input bit sof);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = p;
    endtask

    task automatic drive_frame(input bit gaps, input int stop, input int gap0);
        for (int i = 0; i < stop; i++) begin
            if (gaps) while ($urandom_range(1, 0) == 0) idle(1);
            send(img[i / W][i % W], i == 0);
            drv_cyc[i] = cyc;
            if (i == 0 && gap0 > 0) idle(gap0);
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        idle(1);
        while (fd_cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        idle(4);
    endtask

    task automatic clear_obs();
        got_q.delete();
        win_q.delete();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); in_sof = 1'($urandom); in_pixel = DW'($urandom);
            @(negedge clk);
            total++;
            if (all_out !== '0) begin bad++; $display("FAIL reset_outputs k=%0d got=%h exp=0", k, all_out); end
        end
`ifdef SOBEL_EDGE_STATS_EN
        total++;
        if (edge_count !== '0) begin bad++; $display("FAIL reset_edge_count got=%0d exp=0", edge_count); end
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        clear_obs();
        for (int i = 0; i < NPIX; i++) send(DW'($urandom), 1'b0);
        wait_done(fd_cnt + 1);
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL nosof_out_valid got=%0d exp=0", got_q.size()); end
        total++;
        if (win_q.size() != 0) begin bad++; $display("FAIL nosof_win_valid got=%0d exp=0", win_q.size()); end
        total++;
        if (fd_cnt != 0) begin bad++; $display("FAIL nosof_frame_done got=%0d exp=0", fd_cnt); end
    endtask

    task automatic test_flat();
        int fd0 = fd_cnt;
        set_flat();
        clear_obs();
        drive_frame(1'b0, NPIX, 0);
        wait_done(fd0 + 1);
        total++;
        if (got_q.size() != NOUT) begin bad++; $display("FAIL flat_count got=%0d exp=%0d", got_q.size(), NOUT); end
        total++;
        if (out_diffs(-1, 1'b1) != 0) begin bad++; $display("FAIL flat_values diffs=%0d exp=0", out_diffs(-1, 1'b1)); end
        total++;
        if (n_edges_after(-1) != 0) begin bad++; $display("FAIL flat_edges got=%0d exp=0", n_edges_after(-1)); end
        total++;
        if (fd_cnt != fd0 + 1) begin bad++; $display("FAIL flat_frame_done got=%0d exp=%0d", fd_cnt - fd0, 1); end
        total++;
        if (!fd_with_ov || got_q.size() == 0 || fd_cyc != got_q[$].cyc) begin
            bad++; $display("FAIL flat_fd_align fd_cyc=%0d last_out_cyc=%0d ov=%0d", fd_cyc,
                            (got_q.size() > 0) ? got_q[$].cyc : -1, fd_with_ov);
        end
    endtask

    task automatic test_step();
        int fd0 = fd_cnt;
        set_step();
        clear_obs();
        drive_frame(1'b0, NPIX, 0);
        wait_done(fd0 + 1);
        total++;
        if (got_q.size() != NOUT) begin bad++; $display("FAIL step_count got=%0d exp=%0d", got_q.size(), NOUT); end
        total++;
        if (out_diffs(-1, 1'b1) != 0) begin bad++; $display("FAIL step_values_latency diffs=%0d exp=0", out_diffs(-1, 1'b1)); end
        total++;
        if (win_diffs(-1) != 0) begin bad++; $display("FAIL step_taps diffs=%0d exp=0", win_diffs(-1)); end
        total++;
        if (n_edges_after(-1) != model_edges()) begin
            bad++; $display("FAIL step_edges got=%0d exp=%0d", n_edges_after(-1), model_edges());
        end
`ifdef SOBEL_EDGE_STATS_EN
        total++;
        if (int'(ec_at_fd) != model_edges()) begin bad++; $display("FAIL step_edge_count got=%0d exp=%0d", ec_at_fd, model_edges()); end
`endif
    endtask

    task automatic test_gaps();
        int fd0 = fd_cnt;
        set_step();
        clear_obs();
        drive_frame(1'b1, NPIX, 0);
        wait_done(fd0 + 1);
        total++;
        if (got_q.size() != NOUT) begin bad++; $display("FAIL gaps_count got=%0d exp=%0d", got_q.size(), NOUT); end
        total++;
        if (out_diffs(-1, 1'b0) != 0) begin bad++; $display("FAIL gaps_values diffs=%0d exp=0", out_diffs(-1, 1'b0)); end
        total++;
        if (fd_cnt != fd0 + 1) begin bad++; $display("FAIL gaps_frame_done got=%0d exp=1", fd_cnt - fd0); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            int fd0 = fd_cnt;
            set_random();
            clear_obs();
            drive_frame(k[0], NPIX, 0);
            wait_done(fd0 + 1);
            total++;
            if (out_diffs(-1, 1'b0) != 0 || got_q.size() != NOUT) begin
                bad++; $display("FAIL random_values k=%0d diffs=%0d count=%0d exp=%0d", k, out_diffs(-1, 1'b0), got_q.size(), NOUT);
            end
            total++;
            if (win_diffs(-1) != 0) begin bad++; $display("FAIL random_taps k=%0d diffs=%0d exp=0", k, win_diffs(-1)); end
        end
    endtask

    // Second frame's sof lands while the first is draining and must be held
    task automatic test_back_to_back();
        int fd0 = fd_cnt;
        int a_last;
        set_random();
        clear_obs();
        drive_frame(1'b0, NPIX, 0);
        a_last = drv_cyc[NPIX - 1];
        set_random();
        drive_frame(1'b0, NPIX, 1);
        wait_done(fd0 + 2);
        total++;
        if (fd_cnt != fd0 + 2) begin bad++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cnt - fd0); end
        total++;
        if (got_q.size() != 2 * NOUT) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2 * NOUT); end
        total++;
        if (out_diffs(a_last + 2, 1'b1) != 0) begin bad++; $display("FAIL b2b_values diffs=%0d exp=0", out_diffs(a_last + 2, 1'b1)); end
        total++;
        if (win_diffs(a_last + 1) != 0) begin bad++; $display("FAIL b2b_taps diffs=%0d exp=0", win_diffs(a_last + 1)); end
    endtask

    task automatic test_resync();
        int fd0 = fd_cnt;
        int se0 = se_cnt;
        int s;
        set_step();
        clear_obs();
        drive_frame(1'b0, 3 * W + 5, 0);
        drive_frame(1'b0, NPIX, 0);
        s = drv_cyc[0];
        wait_done(fd0 + 1);
        total++;
        if (se_cnt != se0 + 1) begin bad++; $display("FAIL resync_sof_err got=%0d exp=1", se_cnt - se0); end
        total++;
        if (fd_cnt != fd0 + 1 || fd_cyc <= drv_cyc[NPIX - 1]) begin
            bad++; $display("FAIL resync_frame_done count=%0d exp=1 fd_cyc=%0d", fd_cnt - fd0, fd_cyc);
        end
        total++;
        if (n_out_after(s) != NOUT) begin bad++; $display("FAIL resync_count got=%0d exp=%0d", n_out_after(s), NOUT); end
        total++;
        if (out_diffs(s, 1'b1) != 0) begin bad++; $display("FAIL resync_values diffs=%0d exp=0", out_diffs(s, 1'b1)); end
        total++;
        if (win_diffs(s) != 0) begin bad++; $display("FAIL resync_taps diffs=%0d exp=0", win_diffs(s)); end
    endtask

    task automatic test_reset_mid();
        int fd0;
        int se0 = se_cnt;
        set_step();
        drive_frame(1'b0, 4 * W + 2, 0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin bad++; $display("FAIL reset_mid_outputs got=%h exp=0", all_out); end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_obs();
        fd0 = fd_cnt;
        set_random();
        drive_frame(1'b1, NPIX, 0);
        wait_done(fd0 + 1);
        total++;
        if (got_q.size() != NOUT) begin bad++; $display("FAIL reset_mid_count got=%0d exp=%0d", got_q.size(), NOUT); end
        total++;
        if (out_diffs(-1, 1'b0) != 0) begin bad++; $display("FAIL reset_mid_values diffs=%0d exp=0", out_diffs(-1, 1'b0)); end
        total++;
        if (fd_cnt != fd0 + 1 || se_cnt != se0) begin
            bad++; $display("FAIL reset_mid_flags fd=%0d exp=1 sof_err=%0d exp=0", fd_cnt - fd0, se_cnt - se0);
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_step();
        test_gaps();
        test_random();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
